// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared CPU package: operand-mux encodings, forwarding-source encodings and
// the bit layout of a hazard tag record.
//
// A tag is a flat vector of width REGNOBITS + TAG_EXTRA_BITS:
//   [REGNOBITS + TAG_VALID_OFS]  valid
//   [REGNOBITS + TAG_WRREG_OFS]  wrreg
//   [REGNOBITS + TAG_ISLOAD_OFS] isload
//   [REGNOBITS-1:0]              regno
// Flags live above the register number so the layout works for any REGNOBITS.
package pipe_hazard_ctrl_pkg;

  // Operand-1 / operand-2 mux encodings used by the execute stage.
  localparam logic [1:0] OP1_RS  = 2'd0;
  localparam logic [1:0] OP1_PC  = 2'd1;
  localparam logic [1:0] OP2_RT  = 2'd0;
  localparam logic [1:0] OP2_IMM = 2'd1;

  // Forwarding source for a decode operand.
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_A  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  // Tag record layout (flag offsets are relative to REGNOBITS).
  localparam int TAG_ISLOAD_OFS = 0;
  localparam int TAG_WRREG_OFS  = 1;
  localparam int TAG_VALID_OFS  = 2;
  localparam int TAG_EXTRA_BITS = 3;

endpackage

// File: rtl/hazard_tag_stage.sv
// One stage of the hazard tag pipeline: a registered tag with asynchronous
// clear and a bubble input that loads an all-zero (invalid) tag instead.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high clear
//   bubble_i load an invalid tag this cycle
//   tag_i    tag from the previous stage
//   tag_o    registered tag
module hazard_tag_stage #(
  parameter int TAGW = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            bubble_i,
  input  logic [TAGW-1:0] tag_i,
  output logic [TAGW-1:0] tag_o
);

  logic [TAGW-1:0] tag_q;
  logic [TAGW-1:0] tag_d;

  // Next tag: an all-zero tag is invalid, so a bubble just clears the record.
  always_comb begin
    if (bubble_i) begin
      tag_d = {TAGW{1'b0}};
    end else begin
      tag_d = tag_i;
    end
  end

  // Tag register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q <= {TAGW{1'b0}};
    end else begin
      tag_q <= tag_d;
    end
  end

  assign tag_o = tag_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks destination tags of the instructions in
// stages A, M and W, selects forwarding sources for the decode operands,
// stalls one cycle on a load-use hazard, flushes on a stage-A mispredict and
// counts stall / flush cycles in saturating counters.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   valid_D                     decode slot holds a real instruction
//   rs_D, rt_D                  decode source register numbers
//   uses_rs_D, uses_rt_D        decode instruction reads rs / rt
//   wrreg_D, wregno_D           decode destination write-enable / number
//   isload_D                    decode instruction is a load
//   mispred_A                   stage-A branch/jump resolved mispredicted
//   stall_F, stall_D            hold PC / hold decode register
//   flush_D, bubble_A           squash decode / insert NOP into A
//   fwd1_sel, fwd2_sel          operand source: 0=regfile 1=A 2=M 3=W
//   stall_cnt, flush_cnt        saturating performance counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REGNOBITS = 4,
  parameter int CNTBITS   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_D,
  input  logic [REGNOBITS-1:0] rs_D,
  input  logic [REGNOBITS-1:0] rt_D,
  input  logic                 uses_rs_D,
  input  logic                 uses_rt_D,
  input  logic                 wrreg_D,
  input  logic [REGNOBITS-1:0] wregno_D,
  input  logic                 isload_D,
  input  logic                 mispred_A,
  output logic                 stall_F,
  output logic                 stall_D,
  output logic                 flush_D,
  output logic                 bubble_A,
  output logic [1:0]           fwd1_sel,
  output logic [1:0]           fwd2_sel,
  output logic [CNTBITS-1:0]   stall_cnt,
  output logic [CNTBITS-1:0]   flush_cnt
);

  localparam int TAGW   = REGNOBITS + TAG_EXTRA_BITS;
  localparam int VB     = REGNOBITS + TAG_VALID_OFS;
  localparam int WB     = REGNOBITS + TAG_WRREG_OFS;
  localparam int LB     = REGNOBITS + TAG_ISLOAD_OFS;
  localparam logic [CNTBITS-1:0] CNT_MAX = {CNTBITS{1'b1}};
  localparam logic [CNTBITS-1:0] CNT_ONE = {{(CNTBITS-1){1'b0}}, 1'b1};

  logic [TAGW-1:0]    tag_dec_s;
  logic [TAGW-1:0]    tag_a_s;
  logic [TAGW-1:0]    tag_m_s;
  logic [TAGW-1:0]    tag_w_s;
  logic               bubble_a_in_s;
  logic               loaduse_s;
  logic [1:0]         fwd1_s;
  logic [1:0]         fwd2_s;
  logic [CNTBITS-1:0] stall_cnt_q;
  logic [CNTBITS-1:0] stall_cnt_d;
  logic [CNTBITS-1:0] flush_cnt_q;
  logic [CNTBITS-1:0] flush_cnt_d;

  // A tag matches a register only if it is valid and actually writes it.
  function automatic logic tag_hit(input logic [TAGW-1:0] t,
                                   input logic [REGNOBITS-1:0] r);
    return t[VB] & t[WB] & (t[REGNOBITS-1:0] == r);
  endfunction

  // Youngest-first source select. A load in A has no data yet, so it is
  // skipped here; the load-use stall covers that case.
  function automatic logic [1:0] fwd_pick(input logic use_src,
                                          input logic [REGNOBITS-1:0] r,
                                          input logic [TAGW-1:0] ta,
                                          input logic [TAGW-1:0] tm,
                                          input logic [TAGW-1:0] tw);
    logic [1:0] sel;
    if (!use_src) begin
      sel = FWD_RF;
    end else if (tag_hit(ta, r) && !ta[LB]) begin
      sel = FWD_A;
    end else if (tag_hit(tm, r)) begin
      sel = FWD_M;
    end else if (tag_hit(tw, r)) begin
      sel = FWD_W;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

  assign tag_dec_s     = {valid_D, wrreg_D, isload_D, wregno_D};
  assign bubble_a_in_s = bubble_A | ~valid_D;

  hazard_tag_stage #(.TAGW(TAGW)) u_tag_a (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (bubble_a_in_s),
    .tag_i    (tag_dec_s),
    .tag_o    (tag_a_s)
  );

  hazard_tag_stage #(.TAGW(TAGW)) u_tag_m (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (1'b0),
    .tag_i    (tag_a_s),
    .tag_o    (tag_m_s)
  );

  hazard_tag_stage #(.TAGW(TAGW)) u_tag_w (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (1'b0),
    .tag_i    (tag_m_s),
    .tag_o    (tag_w_s)
  );

  // Load-use detection and raw forwarding selects.
  always_comb begin
    loaduse_s = valid_D & tag_a_s[LB] &
                ((uses_rs_D & tag_hit(tag_a_s, rs_D)) |
                 (uses_rt_D & tag_hit(tag_a_s, rt_D)));
    fwd1_s    = fwd_pick(uses_rs_D, rs_D, tag_a_s, tag_m_s, tag_w_s);
    fwd2_s    = fwd_pick(uses_rt_D, rt_D, tag_a_s, tag_m_s, tag_w_s);
  end

  // Control outputs. Reset keeps decode squashed; a mispredict wins over a
  // load-use stall because the stalled instruction is wrong-path anyway.
  always_comb begin
    stall_F  = 1'b0;
    stall_D  = 1'b0;
    flush_D  = 1'b0;
    bubble_A = 1'b0;
    fwd1_sel = fwd1_s;
    fwd2_sel = fwd2_s;
    if (reset) begin
      flush_D  = 1'b1;
      bubble_A = 1'b1;
      fwd1_sel = FWD_RF;
      fwd2_sel = FWD_RF;
    end else if (mispred_A) begin
      flush_D  = 1'b1;
      bubble_A = 1'b1;
    end else if (loaduse_s) begin
      stall_F  = 1'b1;
      stall_D  = 1'b1;
      bubble_A = 1'b1;
    end else begin
      stall_F  = 1'b0;
      stall_D  = 1'b0;
    end
  end

  // Saturating next-count for both performance counters.
  always_comb begin
    if (stall_D && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_D && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Counter registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= {CNTBITS{1'b0}};
      flush_cnt_q <= {CNTBITS{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_D;
  logic [3:0] rs_D, rt_D, wregno_D;
  logic       uses_rs_D, uses_rt_D, wrreg_D, isload_D, mispred_A;

  logic        stall_F, stall_D, flush_D, bubble_A;
  logic [1:0]  fwd1_sel, fwd2_sel;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s4_stall_F, s4_stall_D, s4_flush_D, s4_bubble_A;
  logic [1:0]  s4_fwd1, s4_fwd2;
  logic [3:0]  s4_stall_cnt, s4_flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REGNOBITS(4), .CNTBITS(16)) dut (
    .clk(clk), .reset(reset), .valid_D(valid_D), .rs_D(rs_D), .rt_D(rt_D),
    .uses_rs_D(uses_rs_D), .uses_rt_D(uses_rt_D), .wrreg_D(wrreg_D),
    .wregno_D(wregno_D), .isload_D(isload_D), .mispred_A(mispred_A),
    .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .bubble_A(bubble_A),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  pipe_hazard_ctrl #(.REGNOBITS(4), .CNTBITS(4)) dut_s4 (
    .clk(clk), .reset(reset), .valid_D(valid_D), .rs_D(rs_D), .rt_D(rt_D),
    .uses_rs_D(uses_rs_D), .uses_rt_D(uses_rt_D), .wrreg_D(wrreg_D),
    .wregno_D(wregno_D), .isload_D(isload_D), .mispred_A(mispred_A),
    .stall_F(s4_stall_F), .stall_D(s4_stall_D), .flush_D(s4_flush_D),
    .bubble_A(s4_bubble_A), .fwd1_sel(s4_fwd1), .fwd2_sel(s4_fwd2),
    .stall_cnt(s4_stall_cnt), .flush_cnt(s4_flush_cnt)
  );

  // Reference model: list of in-flight instructions, index 0 = youngest (A).
  bit m_v[3], m_w[3], m_l[3];
  int m_r[3];
  int m_stall, m_flush, m_stall4, m_flush4;
  bit e_stall, e_flush, e_bubble;
  int e_fwd1, e_fwd2;

  function automatic int m_src(bit use_src, int r);
    if (!use_src) return 0;
    for (int k = 0; k < 3; k++) begin
      if (m_v[k] && m_w[k] && m_r[k] == r) begin
        if (k == 0 && m_l[k]) continue;
        return k + 1;
      end
    end
    return 0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_v[k] = 0; m_w[k] = 0; m_l[k] = 0; m_r[k] = 0;
    end
    m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
  endtask

  task automatic model_eval();
    bit lu;
    lu = valid_D && m_v[0] && m_w[0] && m_l[0] &&
         ((uses_rs_D && m_r[0] == int'(rs_D)) || (uses_rt_D && m_r[0] == int'(rt_D)));
    if (reset) begin
      e_stall = 0; e_flush = 1; e_bubble = 1; e_fwd1 = 0; e_fwd2 = 0;
    end else begin
      e_flush  = mispred_A;
      e_stall  = lu && !mispred_A;
      e_bubble = mispred_A || lu;
      e_fwd1   = m_src(uses_rs_D, int'(rs_D));
      e_fwd2   = m_src(uses_rt_D, int'(rt_D));
    end
  endtask

  task automatic model_adv();
    if (reset) begin
      model_clear();
    end else begin
      if (e_stall) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall4 < 15) m_stall4++;
      end
      if (e_flush) begin
        if (m_flush < 65535) m_flush++;
        if (m_flush4 < 15) m_flush4++;
      end
      for (int k = 2; k > 0; k--) begin
        m_v[k] = m_v[k-1]; m_w[k] = m_w[k-1]; m_l[k] = m_l[k-1]; m_r[k] = m_r[k-1];
      end
      if (e_bubble || !valid_D) begin
        m_v[0] = 0; m_w[0] = 0; m_l[0] = 0; m_r[0] = 0;
      end else begin
        m_v[0] = 1; m_w[0] = wrreg_D; m_l[0] = isload_D; m_r[0] = int'(wregno_D);
      end
    end
  endtask

  task automatic set_dec(bit v, int rs, int rt, bit urs, bit urt, bit wr, int wn, bit ld);
    valid_D = v; rs_D = 4'(rs); rt_D = 4'(rt); uses_rs_D = urs; uses_rt_D = urt;
    wrreg_D = wr; wregno_D = 4'(wn); isload_D = ld;
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    model_adv();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_dec(1, 1, 2, 1, 1, 1, 3, 0);
    mispred_A = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    n_vec++;
    if ({stall_F, stall_D, flush_D, bubble_A} !== 4'b0011) begin
      n_err++; $display("FAIL reset_ctrl got=%b want=0011", {stall_F, stall_D, flush_D, bubble_A});
    end
    n_vec++;
    if ({fwd1_sel, fwd2_sel, stall_cnt, flush_cnt} !== 36'd0) begin
      n_err++; $display("FAIL reset_fwd_cnt fwd1=%0d fwd2=%0d sc=%0d fc=%0d want all 0",
                        fwd1_sel, fwd2_sel, stall_cnt, flush_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_fwd_a();
    int sc;
    set_dec(1, 0, 0, 0, 0, 1, 3, 0); step();
    set_dec(1, 3, 1, 1, 0, 1, 4, 0); #1;
    sc = m_stall;
    n_vec++;
    if (fwd1_sel !== 2'd1 || stall_D !== 1'b0 || stall_F !== 1'b0) begin
      n_err++; $display("FAIL fwd_a fwd1=%0d stall_D=%b want 1/0", fwd1_sel, stall_D);
    end
    step();
    n_vec++;
    if (stall_cnt !== 16'(sc)) begin
      n_err++; $display("FAIL fwd_a_cnt got=%0d want=%0d", stall_cnt, sc);
    end
  endtask

  task automatic test_load_use();
    int sc;
    set_dec(1, 0, 0, 0, 0, 1, 5, 1); step();
    set_dec(1, 0, 5, 0, 1, 1, 6, 0); #1;
    sc = m_stall;
    n_vec++;
    if ({stall_F, stall_D, bubble_A, flush_D} !== 4'b1110) begin
      n_err++; $display("FAIL loaduse_stall got=%b want=1110", {stall_F, stall_D, bubble_A, flush_D});
    end
    step(); #1;
    n_vec++;
    if (stall_D !== 1'b0 || fwd2_sel !== 2'd2) begin
      n_err++; $display("FAIL loaduse_after stall_D=%b fwd2=%0d want 0/2", stall_D, fwd2_sel);
    end
    n_vec++;
    if (stall_cnt !== 16'(sc + 1)) begin
      n_err++; $display("FAIL loaduse_cnt got=%0d want=%0d", stall_cnt, sc + 1);
    end
    step();
  endtask

  task automatic test_priority();
    set_dec(1, 0, 0, 0, 0, 1, 7, 0); step();
    set_dec(1, 0, 0, 0, 0, 1, 1, 0); step();
    set_dec(1, 0, 0, 0, 0, 1, 7, 0); step();
    set_dec(1, 7, 1, 1, 1, 0, 0, 0); #1;
    n_vec++;
    if (fwd1_sel !== 2'd1 || fwd2_sel !== 2'd2) begin
      n_err++; $display("FAIL priority fwd1=%0d fwd2=%0d want 1/2", fwd1_sel, fwd2_sel);
    end
    // wrreg=0 tag with matching regno must be ignored
    set_dec(1, 0, 0, 0, 0, 0, 9, 1); step();
    set_dec(1, 9, 9, 1, 1, 0, 0, 0); #1;
    n_vec++;
    if (fwd1_sel !== 2'd0 || fwd2_sel !== 2'd0 || stall_D !== 1'b0) begin
      n_err++; $display("FAIL nowrite fwd1=%0d fwd2=%0d stall=%b want 0/0/0", fwd1_sel, fwd2_sel, stall_D);
    end
    // register 0 is an ordinary register
    set_dec(1, 0, 0, 0, 0, 1, 0, 0); step();
    set_dec(1, 0, 0, 1, 0, 0, 0, 0); #1;
    n_vec++;
    if (fwd1_sel !== 2'd1) begin
      n_err++; $display("FAIL reg0 fwd1=%0d want 1", fwd1_sel);
    end
    step();
  endtask

  task automatic test_mispred_loaduse();
    int sc, fc;
    set_dec(1, 0, 0, 0, 0, 1, 5, 1); step();
    set_dec(1, 5, 0, 1, 0, 1, 6, 0); mispred_A = 1'b1; #1;
    sc = m_stall; fc = m_flush;
    n_vec++;
    if ({flush_D, bubble_A, stall_D, stall_F} !== 4'b1100) begin
      n_err++; $display("FAIL mispred_ctrl got=%b want=1100", {flush_D, bubble_A, stall_D, stall_F});
    end
    step();
    mispred_A = 1'b0;
    n_vec++;
    if (flush_cnt !== 16'(fc + 1) || stall_cnt !== 16'(sc)) begin
      n_err++; $display("FAIL mispred_cnt fc=%0d sc=%0d want %0d/%0d", flush_cnt, stall_cnt, fc + 1, sc);
    end
  endtask

  task automatic test_saturation();
    repeat (16) begin
      set_dec(1, 0, 0, 0, 0, 1, 2, 1); step();
      set_dec(1, 2, 0, 1, 0, 1, 3, 0); step(); step();
    end
    set_dec(0, 0, 0, 0, 0, 0, 0, 0); #1;
    n_vec++;
    if (s4_stall_cnt !== 4'hF || m_stall4 != 15) begin
      n_err++; $display("FAIL stall_sat got=%h want=f", s4_stall_cnt);
    end
    n_vec++;
    if (stall_cnt !== 16'(m_stall)) begin
      n_err++; $display("FAIL stall_cnt_wide got=%0d want=%0d", stall_cnt, m_stall);
    end
    mispred_A = 1'b1;
    repeat (20) step();
    mispred_A = 1'b0; #1;
    n_vec++;
    if (s4_flush_cnt !== 4'hF || flush_cnt !== 16'(m_flush)) begin
      n_err++; $display("FAIL flush_sat s4=%h wide=%0d want f/%0d", s4_flush_cnt, flush_cnt, m_flush);
    end
  endtask

  task automatic test_reset_midflight();
    set_dec(1, 0, 0, 0, 0, 1, 1, 0); step();
    set_dec(1, 0, 0, 0, 0, 1, 2, 0); step();
    set_dec(1, 0, 0, 0, 0, 1, 3, 1); step();
    set_dec(1, 3, 2, 1, 1, 1, 4, 0); #1;
    reset = 1'b1; model_clear(); #1;
    n_vec++;
    if ({flush_D, bubble_A, stall_D, stall_F, fwd1_sel, fwd2_sel} !== 8'b1100_0000 ||
        stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      n_err++; $display("FAIL midreset ctrl=%b sc=%0d fc=%0d want 11000000/0/0",
                        {flush_D, bubble_A, stall_D, stall_F, fwd1_sel, fwd2_sel}, stall_cnt, flush_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    set_dec(1, 3, 1, 1, 1, 1, 4, 0); #1;
    n_vec++;
    if ({fwd1_sel, fwd2_sel, stall_D, flush_D} !== 6'b0) begin
      n_err++; $display("FAIL after_reset fwd1=%0d fwd2=%0d stall=%b flush=%b want 0",
                        fwd1_sel, fwd2_sel, stall_D, flush_D);
    end
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_dec(($urandom_range(0, 3) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
              $urandom_range(0, 3), ($urandom_range(0, 2) == 0));
      mispred_A = ($urandom_range(0, 7) == 0);
      #1;
      model_eval();
      n_vec++;
      if ({stall_F, stall_D, flush_D, bubble_A, fwd1_sel, fwd2_sel} !==
          {e_stall, e_stall, e_flush, e_bubble, 2'(e_fwd1), 2'(e_fwd2)}) begin
        n_err++; $display("FAIL random[%0d] got=%b want=%b", i,
                          {stall_F, stall_D, flush_D, bubble_A, fwd1_sel, fwd2_sel},
                          {e_stall, e_stall, e_flush, e_bubble, 2'(e_fwd1), 2'(e_fwd2)});
      end
      step();
    end
    mispred_A = 1'b0; #1;
    n_vec++;
    if (stall_cnt !== 16'(m_stall) || flush_cnt !== 16'(m_flush) ||
        s4_stall_cnt !== 4'(m_stall4) || s4_flush_cnt !== 4'(m_flush4)) begin
      n_err++; $display("FAIL random_cnt sc=%0d fc=%0d s4=%0d/%0d want %0d/%0d/%0d/%0d",
                        stall_cnt, flush_cnt, s4_stall_cnt, s4_flush_cnt,
                        m_stall, m_flush, m_stall4, m_flush4);
    end
  endtask

  initial begin
    reset = 1'b1;
    mispred_A = 1'b0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    test_reset();
    test_fwd_a();
    test_load_use();
    test_priority();
    test_mispred_loaduse();
    test_saturation();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REGNOBITS, default 4, register-number width.
REQ-002 SHALL have parameter CNTBITS, default 16, performance-counter width.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port reset, input, 1, reset (asynchronous, active-high).
REQ-005 SHALL have port valid_D, input, 1, decode slot holds a real instruction.
REQ-006 SHALL have ports rs_D and rt_D, input, REGNOBITS each, source register numbers in decode.
REQ-007 SHALL have ports uses_rs_D and uses_rt_D, input, 1 each, decode instruction reads rs / rt.
REQ-008 SHALL have ports wrreg_D, input, 1, and wregno_D, input, REGNOBITS, decode destination write-enable and number.
REQ-009 SHALL have port isload_D, input, 1, decode instruction is LW.
REQ-010 SHALL have port mispred_A, input, 1, branch or jump in stage A resolved mispredicted.
REQ-011 SHALL have ports stall_F and stall_D, output, 1 each, hold PC and hold the decode register.
REQ-012 SHALL have ports flush_D and bubble_A, output, 1 each, squash decode and insert a NOP into A.
REQ-013 SHALL have ports fwd1_sel and fwd2_sel, output, 2 each, operand source: 0=regfile, 1=A, 2=M, 3=W.
REQ-014 SHALL have ports stall_cnt and flush_cnt, output, CNTBITS each, performance counters.

Function
REQ-015 SHALL keep a tag pipeline A, M, W; each stage holds {valid, wrreg, regno, isload}.
REQ-016 SHALL, every cycle, shift W<=M and M<=A; A<=decode tag, or an invalid tag when bubble_A=1 or valid_D=0.
REQ-017 SHALL define hit_X(r) as tag X valid and wrreg and regno==r; a source is checked only when its uses_*_D=1.
REQ-018 SHALL assert loaduse=1 combinationally when valid_D and A is an isload tag with hit_A on either used source.
REQ-019 SHALL drive stall_F=stall_D=bubble_A=1 on loaduse with no mispred_A, giving exactly one stall cycle per load-use pair.
REQ-020 SHALL, on mispred_A, drive flush_D=1, bubble_A=1, stall_F=stall_D=0; mispred_A overrides loaduse.
REQ-021 SHALL select fwd*_sel with youngest-first priority A>M>W, else 0; sel=1 SHALL NOT be produced for a load tag in A.
REQ-022 SHALL make all outputs other than the counters combinational from inputs and tags, with zero latency.
REQ-023 SHALL increment stall_cnt on each cycle where stall_D=1, and flush_cnt on each cycle where flush_D=1.
REQ-024 SHALL saturate both counters at all-ones; they SHALL NOT wrap.
REQ-025 SHALL treat register 0 like any other register; there is no hardwired zero.
REQ-026 SHALL NOT forward or stall on a tag whose wrreg=0, even when regno matches.

Reset
REQ-027 SHALL asynchronously clear all tag valid bits and both counters while reset=1.
REQ-028 SHALL hold stall_F=stall_D=0 and fwd*_sel=0 during reset, with flush_D=bubble_A=1 so no instruction is admitted.
REQ-029 SHALL drop any tags in flight when reset is asserted mid-operation; the first cycle after deassert SHALL have no hazards.

Structure
REQ-030 SHALL place the FWD_RF/FWD_A/FWD_M/FWD_W encodings and the tag record layout in the shared CPU package next to the OP1/OP2 constants.
REQ-031 SHALL use one sub-module, hazard_tag_stage, instantiated three times: a registered tag with async clear and a bubble input.

Verification
REQ-032 Case: ADD r3 in A, decode reads rs=3 -> fwd1_sel=1, no stall, stall_cnt unchanged.
REQ-033 Case: LW r5 in A, decode reads rt=5 -> one cycle with stall_F=stall_D=bubble_A=1; next cycle fwd2_sel=2; stall_cnt+1.
REQ-034 Case: r7 written in both A and W, decode reads rs=7 -> fwd1_sel=1.
REQ-035 Case: mispred_A=1 coinciding with a load-use hazard -> flush_D=1, bubble_A=1, stall_D=0; flush_cnt+1, stall_cnt unchanged.
REQ-036 Case: counter preloaded to 0xFFFF, further stall -> stall_cnt stays 0xFFFF.
REQ-037 Case: reset pulsed with three valid tags in flight -> tags cleared immediately; decode reading those registers after deassert gives fwd=0 and no stall.
